// File: rtl/ysyx_25030081_ifu.sv
// Instruction-fetch sequencer: owns the PC and moves one instruction at a time through fetch, issue, execute and commit.
// Optional IFU_MISALIGN_TRAP_EN: a misaligned commit target faults instead of being silently aligned.
module ysyx_25030081_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] commit_next_pc,
  output logic                  fetch_fault,
  output logic [63:0]           retire_cnt
);

  // state | meaning
  // REQ   | fetch request presented at pc, waiting for acceptance
  // WAIT  | request accepted, waiting for the response pulse
  // ISSUE | instruction offered to decode
  // EXEC  | instruction in flight, waiting for commit
  // FAULT | bus error (or misaligned target) seen; parked until reset
  localparam logic [2:0] S_REQ   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [63:0]           retire_q;
  logic [DATA_WIDTH-1:0] next_pc_aligned;
  logic                  next_pc_misaligned;

  assign next_pc_aligned    = commit_next_pc & ALIGN_MASK;
  assign next_pc_misaligned = (commit_next_pc & ~ALIGN_MASK) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      retire_q <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              state <= S_FAULT;
            end else begin
              inst_q <= imem_rsp_data;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (inst_ready) state <= S_EXEC;
        end
        S_EXEC: begin
          if (commit_valid) begin
            // the instruction did complete, so it counts even if its target faults
            retire_q <= retire_q + 64'd1;
`ifdef IFU_MISALIGN_TRAP_EN
            if (next_pc_misaligned) begin
              state <= S_FAULT;
            end else begin
              pc_q  <= next_pc_aligned;
              state <= S_REQ;
            end
`else
            pc_q  <= next_pc_aligned;
            state <= S_REQ;
`endif
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

`ifndef IFU_MISALIGN_TRAP_EN
  logic unused_misaligned;
  assign unused_misaligned = next_pc_misaligned;
`endif

  // every output is a register or a pure decode of state
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc_q;
  assign inst_valid     = (state == S_ISSUE);
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign fetch_fault    = (state == S_FAULT);
  assign retire_cnt     = retire_q;

endmodule

// File: doc/ysyx_25030081_ifu.md
# ysyx_25030081_ifu

Instruction-fetch sequencer for the NPC core. Holds the architectural PC register and walks each instruction through fetch, issue, execute and commit, one instruction at a time. Requests the instruction from memory over a valid/ready handshake, presents it to decode, then waits for commit. At commit it loads the PC from the combinational next-PC logic: the core drives `pc` into that logic and receives `commit_next_pc` back.

## Interface
- `DATA_WIDTH`, 32, width of PC, address and instruction
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  DATA_WIDTH  fetch address, equals `pc`
- `imem_rsp_valid`  in  1  fetch response valid; single-cycle pulse
- `imem_rsp_data`  in  DATA_WIDTH  fetched instruction
- `imem_rsp_err`  in  1  bus error, qualified by `imem_rsp_valid`
- `inst_valid`  out  1  instruction available to decode
- `inst_ready`  in  1  decode accepts instruction
- `inst`  out  DATA_WIDTH  latched instruction
- `pc`  out  DATA_WIDTH  current PC, fed to the next-PC logic
- `commit_valid`  in  1  current instruction completed
- `commit_next_pc`  in  DATA_WIDTH  next-PC logic output
- `fetch_fault`  out  1  sticky fault indication
- `retire_cnt`  out  64  committed-instruction counter

## Operation
- States: REQ, WAIT, ISSUE, EXEC, FAULT. Reset state is REQ.
- REQ:
  - `imem_req_valid`=1 and `imem_addr`=`pc`.
  - `imem_req_valid && imem_req_ready` moves to WAIT.
- WAIT:
  - `imem_req_valid`=0.
  - On `imem_rsp_valid` with `imem_rsp_err`=0: latch `imem_rsp_data` into `inst` and move to ISSUE.
  - On `imem_rsp_valid` with `imem_rsp_err`=1: move to FAULT.
- ISSUE:
  - `inst_valid`=1; `inst` is held stable.
  - `inst_valid && inst_ready` moves to EXEC.
- EXEC:
  - On `commit_valid`: `pc`<=`commit_next_pc`, `retire_cnt`+=1, then move to REQ.
- FAULT:
  - `fetch_fault`=1; no further requests are made.
  - Exit only via reset.
- Ignored inputs:
  - `imem_rsp_valid` is ignored outside WAIT, including a pulse in the same cycle as request acceptance.
  - `commit_valid` is ignored outside EXEC.
  - `inst_ready` is ignored outside ISSUE.
- `retire_cnt` wraps from 2^64-1 to 0 with no flag.
- Once a request is asserted, `imem_req_valid`/`imem_addr` stay stable until accepted (no retraction).
- `pc` changes only on commit or reset.

## Timing
- Reset values: `pc`=RESET_PC, `inst`=0, `retire_cnt`=0, `inst_valid`=0, `fetch_fault`=0, state=REQ.
  - `imem_req_valid` is 1 combinationally while in REQ, so it is 1 during and immediately after reset.
- Reset mid-operation clears everything asynchronously. A response arriving after reset release is dropped, because the FSM is in REQ.
- Minimum instruction period is 4 cycles, with ready, response and commit each arriving at the earliest opportunity:
  - REQ accepted in cycle 0.
  - Response in cycle 1.
  - Issue accepted in cycle 2.
  - Commit in cycle 3.
  - Next request in cycle 4.
- Response latency from request accept is ≥1 cycle; longer latencies are tolerated indefinitely.
- All outputs are registered or decoded from state only; no combinational input-to-output path except through the FSM state.

## Configuration
- `IFU_MISALIGN_TRAP_EN` defined:
  - A commit with `commit_next_pc[1:0]`≠0 moves to FAULT.
  - `pc` is not updated.
  - `retire_cnt` still increments, because the faulting instruction did commit.
- Not defined: `pc`<=`{commit_next_pc[DATA_WIDTH-1:2],2'b00}`; FAULT is reachable only via `imem_rsp_err`.

## Test plan
- Reset release, `imem_req_ready`=1, response after 1 cycle with 32'h0000_0013, `inst_ready`=1, commit with `commit_next_pc`=32'h8000_0004 -> next request at addr 32'h8000_0004 in cycle 4; `retire_cnt`=1.
- `imem_req_ready` low for 5 cycles -> `imem_req_valid`=1 and addr 32'h8000_0000 held all 5 cycles; WAIT entered only on the acceptance cycle.
- `inst_ready` low for 3 cycles in ISSUE, plus spurious `commit_valid`=1 with next_pc 32'h1234_5678 during ISSUE -> `inst` stable; `pc` unchanged; `retire_cnt` unchanged.
- Response with `imem_rsp_err`=1 -> `fetch_fault`=1 next cycle and stays 1; no further `imem_req_valid` over 20 cycles; `rst_n` pulse clears it and a fetch restarts at RESET_PC.
- Commit with `commit_next_pc`=32'h8000_0102:
  - With the macro: FAULT, `pc`=32'h8000_0000.
  - Without the macro: next fetch at addr 32'h8000_0100.
- `rst_n` asserted while in WAIT, response pulse 1 cycle after release -> response ignored; `inst_valid` stays 0; new request at RESET_PC.
